// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch prediction tracking FIFO, mispredict redirect/flush, predictor update port
// Optional statistics counters enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        BR_CLK,
   input  logic        BR_RST,
   input  logic        BR_DEC_PUSH,
   input  logic        BR_DEC_PRED_TAKEN,
   input  logic [9:0]  BR_DEC_ADDR,
   input  logic [9:0]  BR_DEC_TARGET,
   input  logic        BR_EX_RESOLVE,
   input  logic        BR_EX_TAKEN,
   output logic        BR_FULL,
   output logic        BR_PC_LD,
   output logic [9:0]  BR_REDIRECT_ADDR,
   output logic        BR_FLUSH,
   output logic        BR_UPD_VALID,
   output logic [9:0]  BR_UPD_ADDR,
   output logic        BR_UPD_TAKEN,
   output logic        BR_ERR,
   output logic [15:0] BR_RESOLVED_CNT,
   output logic [15:0] BR_MISPRED_CNT
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0]  DEPTH_C     = CW'(DEPTH);
   localparam logic [FCW-1:0] FLUSH_LOAD  = FCW'(FLUSH_CYCLES - 1);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   typedef struct packed {
      logic       pred;
      logic [9:0] addr;
      logic [9:0] tgt;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
   logic            pc_ld_q, pc_ld_d;
   logic [9:0]      redirect_q, redirect_d;
   logic            upd_valid_q, upd_valid_d;
   logic [9:0]      upd_addr_q, upd_addr_d;
   logic            upd_taken_q, upd_taken_d;
   logic            err_q, err_d;

   entry_t head;
   logic   flushing, full, resolve_ok, mispred, push_ok;

   always_comb begin
      head       = mem_q[rd_ptr_q];
      flushing   = (state_q == S_FLUSH);
      full       = (count_q == DEPTH_C);
      resolve_ok = BR_EX_RESOLVE && !flushing && (count_q != '0);
      mispred    = resolve_ok && (head.pred != BR_EX_TAKEN);
      // Pushes in the mispredict cycle are wrong-path and never enter the FIFO.
      push_ok    = BR_DEC_PUSH && !flushing && !full && !mispred;
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_ld_d     = 1'b0;
      redirect_d  = redirect_q;
      upd_valid_d = 1'b0;
      upd_addr_d  = upd_addr_q;
      upd_taken_d = upd_taken_q;
      err_d       = BR_EX_RESOLVE && !flushing && (count_q == '0);

      if (push_ok) begin
         mem_d[wr_ptr_q] = '{pred: BR_DEC_PRED_TAKEN, addr: BR_DEC_ADDR, tgt: BR_DEC_TARGET};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (resolve_ok) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         upd_valid_d = 1'b1;
         upd_addr_d  = head.addr;
         upd_taken_d = BR_EX_TAKEN;
      end
      if (push_ok && !resolve_ok) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && resolve_ok) begin
         count_d = count_q - CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (mispred) begin
               state_d     = S_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - FCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (mispred) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         pc_ld_d    = 1'b1;
         redirect_d = BR_EX_TAKEN ? head.tgt : head.addr + 10'd1;
      end
   end

   always_ff @(posedge BR_CLK) begin
      if (BR_RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         flush_cnt_q <= '0;
         pc_ld_q     <= 1'b0;
         redirect_q  <= '0;
         upd_valid_q <= 1'b0;
         upd_addr_q  <= '0;
         upd_taken_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pc_ld_q     <= pc_ld_d;
         redirect_q  <= redirect_d;
         upd_valid_q <= upd_valid_d;
         upd_addr_q  <= upd_addr_d;
         upd_taken_q <= upd_taken_d;
         err_q       <= err_d;
      end
   end

   assign BR_FULL          = full;
   assign BR_PC_LD         = pc_ld_q;
   assign BR_REDIRECT_ADDR = redirect_q;
   assign BR_FLUSH         = (state_q == S_FLUSH);
   assign BR_UPD_VALID     = upd_valid_q;
   assign BR_UPD_ADDR      = upd_addr_q;
   assign BR_UPD_TAKEN     = upd_taken_q;
   assign BR_ERR           = err_q;

`ifdef BRU_STATS_EN
   logic [15:0] resolved_cnt_q, resolved_cnt_d, mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      resolved_cnt_d = resolved_cnt_q;
      mispred_cnt_d  = mispred_cnt_q;
      if (resolve_ok && resolved_cnt_q != 16'hFFFF) begin
         resolved_cnt_d = resolved_cnt_q + 16'd1;
      end
      if (mispred && mispred_cnt_q != 16'hFFFF) begin
         mispred_cnt_d = mispred_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge BR_CLK) begin
      if (BR_RST) begin
         resolved_cnt_q <= '0;
         mispred_cnt_q  <= '0;
      end else begin
         resolved_cnt_q <= resolved_cnt_d;
         mispred_cnt_q  <= mispred_cnt_d;
      end
   end

   assign BR_RESOLVED_CNT = resolved_cnt_q;
   assign BR_MISPRED_CNT  = mispred_cnt_q;
`else
   assign BR_RESOLVED_CNT = 16'h0000;
   assign BR_MISPRED_CNT  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit with queue-based reference model
module tb_branch_resolve_unit;

   localparam int DEPTH        = 4;
   localparam int FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0, pred = 1'b0, resolve = 1'b0, taken = 1'b0;
   logic [9:0]  addr = '0, tgt = '0;
   logic        full, pc_ld, flush, upd_valid, upd_taken, err;
   logic [9:0]  redirect, upd_addr;
   logic [15:0] resolved_cnt, mispred_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .BR_CLK(clk), .BR_RST(rst),
      .BR_DEC_PUSH(push), .BR_DEC_PRED_TAKEN(pred), .BR_DEC_ADDR(addr), .BR_DEC_TARGET(tgt),
      .BR_EX_RESOLVE(resolve), .BR_EX_TAKEN(taken),
      .BR_FULL(full), .BR_PC_LD(pc_ld), .BR_REDIRECT_ADDR(redirect), .BR_FLUSH(flush),
      .BR_UPD_VALID(upd_valid), .BR_UPD_ADDR(upd_addr), .BR_UPD_TAKEN(upd_taken),
      .BR_ERR(err), .BR_RESOLVED_CNT(resolved_cnt), .BR_MISPRED_CNT(mispred_cnt)
   );

   typedef struct {
      logic       pred;
      logic [9:0] addr;
      logic [9:0] tgt;
   } br_t;

   typedef struct {
      logic        full, pc_ld, flush, upd_valid, upd_taken, err;
      logic [9:0]  redirect, upd_addr;
      logic [15:0] res_cnt, mis_cnt;
   } exp_t;

   br_t  model_q[$];
   exp_t exp_q[$];
   int   flush_rem = 0;
   int   m_res = 0, m_mis = 0;
   int   n_cmp = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
      end
   endtask

   // Reference model: one call per clock edge, describing outputs just after that edge.
   task automatic cycle(input logic p, input logic pt, input logic [9:0] a, input logic [9:0] t,
                        input logic r, input logic tk, input logic rs);
      exp_t e;
      br_t  h;
      bit   was_full, flushing, mis;
      @(negedge clk);
      rst = rs; push = p; pred = pt; addr = a; tgt = t; resolve = r; taken = tk;
      e = '{default: '0};
      mis = 0;
      if (rs) begin
         model_q.delete();
         flush_rem = 0;
         m_res = 0;
         m_mis = 0;
      end else begin
         flushing = (flush_rem > 0);
         was_full = (model_q.size() == DEPTH);
         if (flushing) flush_rem--;
         if (r && !flushing) begin
            if (model_q.size() == 0) begin
               e.err = 1;
            end else begin
               h = model_q.pop_front();
               e.upd_valid = 1;
               e.upd_addr  = h.addr;
               e.upd_taken = tk;
               if (m_res < 65535) m_res++;
               if (h.pred != tk) begin
                  mis = 1;
                  if (m_mis < 65535) m_mis++;
                  e.pc_ld    = 1;
                  e.redirect = tk ? h.tgt : 10'((int'(h.addr) + 1) % 1024);
                  model_q.delete();
                  flush_rem = FLUSH_CYCLES;
               end
            end
         end
         if (p && !flushing && !was_full && !mis) model_q.push_back('{pt, a, t});
      end
      e.flush = (flush_rem > 0);
      e.full  = (model_q.size() == DEPTH);
`ifdef BRU_STATS_EN
      e.res_cnt = 16'(m_res);
      e.mis_cnt = 16'(m_mis);
`endif
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("full", full, e.full);
            chk("pc_ld", pc_ld, e.pc_ld);
            if (e.pc_ld) chk("redirect", redirect, e.redirect);
            chk("flush", flush, e.flush);
            chk("upd_valid", upd_valid, e.upd_valid);
            if (e.upd_valid) begin
               chk("upd_addr", upd_addr, e.upd_addr);
               chk("upd_taken", upd_taken, e.upd_taken);
            end
            chk("err", err, e.err);
            chk("resolved_cnt", resolved_cnt, e.res_cnt);
            chk("mispred_cnt", mispred_cnt, e.mis_cnt);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : stim
      int drain;
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      // Correct prediction
      cycle(1, 1, 10'h010, 10'h020, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // Not-taken mispredict at top of address space wraps to 0
      cycle(1, 1, 10'h3FF, 10'h155, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      idle(3);
      // Taken mispredict with younger wrong-path entries plus a same-cycle push
      cycle(1, 0, 10'h040, 10'h07A, 0, 0, 0);
      cycle(1, 1, 10'h041, 10'h100, 0, 0, 0);
      cycle(1, 1, 10'h042, 10'h101, 0, 0, 0);
      cycle(1, 0, 10'h043, 10'h102, 1, 1, 0);
      idle(3);
      cycle(0, 0, 0, 0, 1, 0, 0);
      // Fill, overflow push, then drain in order
      for (int i = 0; i < DEPTH + 1; i++) cycle(1, 1, 10'(10'h100 + i), 10'h0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, 1, 0);
      // Empty resolve, then reset during flush
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(1, 0, 10'h200, 10'h210, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0, 1);
      idle(2);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 3) != 0, $urandom % 2,
               ($urandom % 8 == 0) ? 10'h3FF : 10'($urandom % 1024), 10'($urandom % 1024),
               ($urandom % 2) == 0, $urandom % 2, ($urandom % 80) == 0);
      end
      idle(2);
      drain = 0;
      while (exp_q.size() != 0 && drain < 20) begin
         @(posedge clk);
         drain++;
      end
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
